touch_keypad_n: RTL and testbench

TOUCH_KEYPAD_N -- requirements
Module: touch_keypad_n

---
 rtl/touch_keypad_n_pkg.sv | 36 +++
 rtl/touch_keypad_n_key_hit.sv | 55 +++++
 rtl/touch_keypad_n.sv | 216 +++++++++++++++++++++
 tb/tb_touch_keypad_n.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/touch_keypad_n_pkg.sv
// Shared definitions for the touch keypad blocks: coordinate widths,
// default key geometry and the keypad debounce FSM state encoding.
package touch_keypad_n_pkg;

  // Touch controller coordinate widths
  localparam int COORD_X_W = 10;
  localparam int COORD_Y_W = 9;

  // Default key geometry used by the touch front-panel blocks
  localparam int DEF_NKEYS     = 3;
  localparam int DEF_X_START   = 15;
  localparam int DEF_KEY_W     = 78;
  localparam int DEF_KEY_PITCH = 110;
  localparam int DEF_Y_TOP     = 11;
  localparam int DEF_Y_BOT     = 90;

  // Default timing
  localparam int DEF_DEB_N   = 4;
  localparam int DEF_RPT_DLY = 32;
  localparam int DEF_RPT_PER = 8;

  // Width of the key index output (up to 8 keys)
  localparam int IDX_W = 3;

  // Width of the hold / repeat-phase counters
  localparam int HOLD_W = 16;

  // Keypad FSM states
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_DEB   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_DEB = 2'd3
  } kp_state_t;

endpackage : touch_keypad_n_pkg

// File: rtl/touch_keypad_n_key_hit.sv
// Combinational decoder: maps a touch coordinate onto one of NKEYS
// rectangular keys laid out in a single horizontal row.
module touch_key_hit
  import touch_keypad_n_pkg::*;
#(
  parameter int NKEYS     = DEF_NKEYS,
  parameter int X_START   = DEF_X_START,
  parameter int KEY_W     = DEF_KEY_W,
  parameter int KEY_PITCH = DEF_KEY_PITCH,
  parameter int Y_TOP     = DEF_Y_TOP,
  parameter int Y_BOT     = DEF_Y_BOT
) (
  input  logic                 touch_valid,
  input  logic [COORD_X_W-1:0] tor_x,
  input  logic [COORD_Y_W-1:0] tor_y,
  output logic                 hit,
  output logic [IDX_W-1:0]     idx
);

  // Overlapping keys would make the decoded index ambiguous
  if (KEY_W >= KEY_PITCH) begin : g_overlap_check
    $error("touch_key_hit: KEY_W must be smaller than KEY_PITCH");
  end

  if (NKEYS < 1 || NKEYS > 8) begin : g_nkeys_check
    $error("touch_key_hit: NKEYS must be in 1..8");
  end

  // Coordinates promoted to int so all bound arithmetic is full width
  int x_i;
  int y_i;

  assign x_i = int'(tor_x);
  assign y_i = int'(tor_y);

  // Inclusive rectangle test for every key, first match wins
  always_comb begin
    hit = 1'b0;
    idx = '0;
    if (touch_valid && (y_i >= Y_TOP) && (y_i <= Y_BOT)) begin
      for (int k = 0; k < NKEYS; k++) begin
        if (!hit && (x_i >= X_START + k * KEY_PITCH) &&
            (x_i <= X_START + k * KEY_PITCH + KEY_W)) begin
          hit = 1'b1;
          idx = IDX_W'(k);
        end else begin
          idx = idx;
        end
      end
    end else begin
      hit = 1'b0;
    end
  end

endmodule : touch_key_hit

// File: rtl/touch_keypad_n.sv
// Debounced touch keypad: decodes touches onto a row of keys, debounces
// press and release, generates auto-repeat and drives one-hot key events.
module touch_keypad_n
  import touch_keypad_n_pkg::*;
#(
  parameter int NKEYS     = DEF_NKEYS,
  parameter int X_START   = DEF_X_START,
  parameter int KEY_W     = DEF_KEY_W,
  parameter int KEY_PITCH = DEF_KEY_PITCH,
  parameter int Y_TOP     = DEF_Y_TOP,
  parameter int Y_BOT     = DEF_Y_BOT,
  parameter int DEB_N     = DEF_DEB_N,
  parameter int RPT_DLY   = DEF_RPT_DLY,
  parameter int RPT_PER   = DEF_RPT_PER
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 touch_valid,
  input  logic [COORD_X_W-1:0] tor_x,
  input  logic [COORD_Y_W-1:0] tor_y,
  output logic [NKEYS-1:0]     key_press,
  output logic [NKEYS-1:0]     key_repeat,
  output logic [NKEYS-1:0]     key_release,
  output logic [NKEYS-1:0]     key_down,
  output logic [IDX_W-1:0]     key_idx
);

  if (DEB_N < 2 || DEB_N > 15) begin : g_deb_check
    $error("touch_keypad_n: DEB_N must be in 2..15");
  end

  if (RPT_DLY < 0 || RPT_DLY >= (1 << HOLD_W) - 1 ||
      RPT_PER < 1 || RPT_PER >= (1 << HOLD_W) - 1) begin : g_rpt_check
    $error("touch_keypad_n: RPT_DLY/RPT_PER out of range");
  end

  localparam logic [3:0]        DEB_LIM = 4'(DEB_N);
  localparam logic [HOLD_W-1:0] DLY_LIM = HOLD_W'(RPT_DLY);
  localparam logic [HOLD_W-1:0] PER_LIM = HOLD_W'(RPT_PER);
  localparam logic [HOLD_W-1:0] HOLD_MAX = {HOLD_W{1'b1}};

  logic             hit;
  logic [IDX_W-1:0] idx;

  touch_key_hit #(
    .NKEYS     (NKEYS),
    .X_START   (X_START),
    .KEY_W     (KEY_W),
    .KEY_PITCH (KEY_PITCH),
    .Y_TOP     (Y_TOP),
    .Y_BOT     (Y_BOT)
  ) u_hit (
    .touch_valid (touch_valid),
    .tor_x       (tor_x),
    .tor_y       (tor_y),
    .hit         (hit),
    .idx         (idx)
  );

  kp_state_t         state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]  cand, cand_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [HOLD_W-1:0] rpt_cnt, rpt_nxt;
  logic              press_evt, repeat_evt, release_evt;
  logic              same_key;
  logic [NKEYS-1:0]  cand_vec;
  logic [NKEYS-1:0]  cand_nxt_vec;
  logic              down_nxt;

  assign same_key = hit && (idx == cand);

  // One-hot expansion of the current and next candidate key index
  always_comb begin
    cand_vec     = '0;
    cand_nxt_vec = '0;
    for (int k = 0; k < NKEYS; k++) begin
      cand_vec[k]     = (cand == IDX_W'(k));
      cand_nxt_vec[k] = (cand_nxt == IDX_W'(k));
    end
  end

  // Next-state, counter and event decode; only sample_en cycles advance
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cand_nxt    = cand;
    hold_nxt    = hold_cnt;
    rpt_nxt     = rpt_cnt;
    press_evt   = 1'b0;
    repeat_evt  = 1'b0;
    release_evt = 1'b0;
    if (sample_en) begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            cand_nxt  = idx;
            cnt_nxt   = 4'd1;
            state_nxt = ST_PRESS_DEB;
          end else begin
            cnt_nxt = 4'd0;
          end
        end
        ST_PRESS_DEB: begin
          if (same_key) begin
            if (cnt + 4'd1 >= DEB_LIM) begin
              state_nxt = ST_PRESSED;
              press_evt = 1'b1;
              cnt_nxt   = 4'd0;
              hold_nxt  = '0;
              rpt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else if (hit) begin
            cand_nxt = idx;
            cnt_nxt  = 4'd1;
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 4'd0;
          end
        end
        ST_PRESSED: begin
          if (same_key) begin
            if (RPT_DLY != 0) begin
              // Delay phase saturates at RPT_DLY, then the phase counter cycles
              if (hold_cnt < DLY_LIM) begin
                hold_nxt = hold_cnt + HOLD_W'(1);
                if (hold_cnt + HOLD_W'(1) == DLY_LIM) begin
                  repeat_evt = 1'b1;
                  rpt_nxt    = '0;
                end else begin
                  rpt_nxt = rpt_cnt;
                end
              end else if (rpt_cnt + HOLD_W'(1) >= PER_LIM) begin
                repeat_evt = 1'b1;
                rpt_nxt    = '0;
              end else begin
                rpt_nxt = rpt_cnt + HOLD_W'(1);
              end
            end else begin
              // Repeat disabled: just track hold time without wrapping
              if (hold_cnt != HOLD_MAX) begin
                hold_nxt = hold_cnt + HOLD_W'(1);
              end else begin
                hold_nxt = hold_cnt;
              end
            end
          end else begin
            cnt_nxt   = 4'd1;
            state_nxt = ST_RELEASE_DEB;
          end
        end
        ST_RELEASE_DEB: begin
          if (same_key) begin
            state_nxt = ST_PRESSED;
            cnt_nxt   = 4'd0;
          end else if (cnt + 4'd1 >= DEB_LIM) begin
            release_evt = 1'b1;
            state_nxt   = ST_IDLE;
            cnt_nxt     = 4'd0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
          cand_nxt  = '0;
          hold_nxt  = '0;
          rpt_nxt   = '0;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  assign down_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_RELEASE_DEB);

  // FSM state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      cand     <= '0;
      hold_cnt <= '0;
      rpt_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cand     <= cand_nxt;
      hold_cnt <= hold_nxt;
      rpt_cnt  <= rpt_nxt;
    end
  end

  // Registered event pulses and held-key level outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      key_press   <= '0;
      key_repeat  <= '0;
      key_release <= '0;
      key_down    <= '0;
      key_idx     <= '0;
    end else begin
      key_press   <= press_evt   ? cand_vec : '0;
      key_repeat  <= repeat_evt  ? cand_vec : '0;
      key_release <= release_evt ? cand_vec : '0;
      key_down    <= down_nxt ? cand_nxt_vec : '0;
      key_idx     <= down_nxt ? cand_nxt : '0;
    end
  end

endmodule : touch_keypad_n

// File: tb/tb_touch_keypad_n.sv
// Directed bench for touch_keypad_n with default parameters.
module tb_touch_keypad_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic       touch_valid;
  logic [9:0] tor_x;
  logic [8:0] tor_y;
  logic [2:0] key_press;
  logic [2:0] key_repeat;
  logic [2:0] key_release;
  logic [2:0] key_down;
  logic [2:0] key_idx;

  int checks = 0;
  int errors = 0;

  touch_keypad_n dut (
    .clk         (clk),
    .reset       (reset),
    .sample_en   (sample_en),
    .touch_valid (touch_valid),
    .tor_x       (tor_x),
    .tor_y       (tor_y),
    .key_press   (key_press),
    .key_repeat  (key_repeat),
    .key_release (key_release),
    .key_down    (key_down),
    .key_idx     (key_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sen;
    logic       tv;
    int         x;
    int         y;
    logic [2:0] p;
    logic [2:0] r;
    logic [2:0] l;
    logic [2:0] d;
    logic [2:0] i;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic sen, input logic tv, input int x, input int y,
                     input logic [2:0] p, input logic [2:0] r, input logic [2:0] l,
                     input logic [2:0] d, input logic [2:0] i);
    vec_t v;
    v.sen = sen; v.tv = tv; v.x = x; v.y = y;
    v.p = p; v.r = r; v.l = l; v.d = d; v.i = i;
    vq.push_back(v);
  endtask

  task automatic step(input logic sen, input logic tv, input int x, input int y);
    sample_en   = sen;
    touch_valid = tv;
    tor_x       = 10'(x);
    tor_y       = 9'(y);
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic check(input string name, input logic [2:0] ep, input logic [2:0] er,
                       input logic [2:0] el, input logic [2:0] ed, input logic [2:0] ei);
    checks++;
    if (key_press !== ep || key_repeat !== er || key_release !== el ||
        key_down !== ed || (ed != 3'b000 && key_idx !== ei)) begin
      errors++;
      $display("FAIL %s got p=%b r=%b l=%b d=%b i=%0d, expected p=%b r=%b l=%b d=%b i=%0d",
               name, key_press, key_repeat, key_release, key_down, key_idx,
               ep, er, el, ed, ei);
    end
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; touch_valid = 1'b0; tor_x = '0; tor_y = '0;

    // Press/release key 0, inclusive corner hits, outside-edge misses
    for (int n = 0; n < 3; n++) add(1'b1, 1'b1, 50, 50, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    add(1'b1, 1'b1, 50, 50, 3'b001, 3'b000, 3'b000, 3'b001, 3'd0);
    add(1'b0, 1'b1, 50, 50, 3'b000, 3'b000, 3'b000, 3'b001, 3'd0);
    for (int n = 0; n < 3; n++) add(1'b1, 1'b0, 50, 50, 3'b000, 3'b000, 3'b000, 3'b001, 3'd0);
    add(1'b1, 1'b0, 50, 50, 3'b000, 3'b000, 3'b001, 3'b000, 3'd0);
    for (int n = 0; n < 3; n++) add(1'b1, 1'b1, 15, 11, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    add(1'b1, 1'b1, 15, 11, 3'b001, 3'b000, 3'b000, 3'b001, 3'd0);
    add(1'b1, 1'b1, 93, 90, 3'b000, 3'b000, 3'b000, 3'b001, 3'd0);
    for (int n = 0; n < 3; n++) add(1'b1, 1'b1, 94, 50, 3'b000, 3'b000, 3'b000, 3'b001, 3'd0);
    add(1'b1, 1'b1, 94, 50, 3'b000, 3'b000, 3'b001, 3'b000, 3'd0);
    for (int n = 0; n < 4; n++) add(1'b1, 1'b1, 14, 50, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    for (int n = 0; n < 4; n++) add(1'b1, 1'b1, 50, 10, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    for (int n = 0; n < 4; n++) add(1'b1, 1'b1, 50, 91, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    for (int n = 0; n < 3; n++) add(1'b1, 1'b1, 125, 50, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    add(1'b1, 1'b1, 125, 50, 3'b010, 3'b000, 3'b000, 3'b010, 3'd1);
    for (int n = 0; n < 3; n++) add(1'b1, 1'b0, 125, 50, 3'b000, 3'b000, 3'b000, 3'b010, 3'd1);
    add(1'b1, 1'b0, 125, 50, 3'b000, 3'b000, 3'b010, 3'b000, 3'd0);
    // Debounce restart: 3 on key 1, then key 2 pressed after 4 samples on key 2
    for (int n = 0; n < 3; n++) add(1'b1, 1'b1, 125, 50, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    for (int n = 0; n < 3; n++) add(1'b1, 1'b1, 250, 50, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    add(1'b1, 1'b1, 250, 50, 3'b100, 3'b000, 3'b000, 3'b100, 3'd2);

    // Reset state, with sample_en and a touch active during reset
    sample_en = 1'b1; touch_valid = 1'b1; tor_x = 10'd50; tor_y = 9'd50;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    reset = 1'b0; sample_en = 1'b0;

    foreach (vq[n]) begin
      step(vq[n].sen, vq[n].tv, vq[n].x, vq[n].y);
      check($sformatf("vec%0d", n), vq[n].p, vq[n].r, vq[n].l, vq[n].d, vq[n].i);
    end

    // Auto-repeat on key 2: hold samples 32, 40 and 48, idle cycles between
    for (int h = 1; h <= 48; h++) begin
      step(1'b1, 1'b1, 250, 50);
      check($sformatf("hold%0d", h), 3'b000,
            (h == 32 || h == 40 || h == 48) ? 3'b100 : 3'b000,
            3'b000, 3'b100, 3'd2);
      step(1'b0, 1'b1, 250, 50);
      check($sformatf("hold_gap%0d", h), 3'b000, 3'b000, 3'b000, 3'b100, 3'd2);
    end

    // Release bounce: 3 no-touch then back on key -> no release
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 1'b0, 250, 50);
      check("rel_bounce", 3'b000, 3'b000, 3'b000, 3'b100, 3'd2);
    end
    step(1'b1, 1'b1, 250, 50);
    check("rel_return", 3'b000, 3'b000, 3'b000, 3'b100, 3'd2);
    for (int n = 1; n <= 4; n++) begin
      step(1'b1, 1'b0, 250, 50);
      check($sformatf("rel_final%0d", n), 3'b000, 3'b000,
            (n == 4) ? 3'b100 : 3'b000, (n == 4) ? 3'b000 : 3'b100, 3'd2);
    end
    step(1'b0, 1'b0, 250, 50);
    check("rel_pulse_once", 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);

    // Reset while pressed: outputs clear, no release, FSM back in IDLE
    for (int n = 1; n <= 4; n++) begin
      step(1'b1, 1'b1, 50, 50);
      check($sformatf("rst_press%0d", n), (n == 4) ? 3'b001 : 3'b000, 3'b000, 3'b000,
            (n == 4) ? 3'b001 : 3'b000, 3'd0);
    end
    reset = 1'b1;
    step(1'b1, 1'b0, 50, 50);
    check("rst_mid_press", 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    checks++;
    if (key_idx !== 3'd0) begin
      errors++;
      $display("FAIL rst_key_idx got %0d expected 0", key_idx);
    end
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      step(1'b1, 1'b0, 50, 50);
      check($sformatf("rst_no_release%0d", n), 3'b000, 3'b000, 3'b000, 3'b000, 3'd0);
    end
    for (int n = 1; n <= 4; n++) begin
      step(1'b1, 1'b1, 50, 50);
      check($sformatf("rst_repress%0d", n), (n == 4) ? 3'b001 : 3'b000, 3'b000, 3'b000,
            (n == 4) ? 3'b001 : 3'b000, 3'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_touch_keypad_n
